// File: rtl/score_pkg.sv
// Shared types and constants for the score bookkeeping stage.
package score_pkg;

  localparam int SCORE_W = 14;
  localparam logic [5:0] POINT_BEST = 6'b000001;

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    OVER_SCORE,
    OVER_BEST
  } state_t;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v,
                                                 input logic [SCORE_W-1:0] max);
    return (v >= max) ? max : v + 1'b1;
  endfunction

endpackage

// File: rtl/score_tracker_ms_tick.sv
// Millisecond prescaler: one-cycle tick every CLK_FREQ/1000 clocks, first tick a full period after clr drops.
// Latency: tick is decoded from the registered count; no backpressure.
module ms_tick #(
  parameter int CLK_FREQ = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int DIV = (CLK_FREQ / 1000 > 0) ? CLK_FREQ / 1000 : 1;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = !clr && (cnt == LAST);

endmodule

// File: rtl/score_tracker.sv
// Game score / session best tracker feeding the seven-segment driver; alternates score and best after game over.
// Latency: input edge acts on state at the sampling edge, data/point one edge later; no backpressure.
module score_tracker
  import score_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int ALT_MS    = 1000,
  parameter int MAX_SCORE = 9999
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               game_start,
  input  logic               pass_pipe,
  input  logic               game_over,
  output logic [19:0]        data,
  output logic [5:0]         point,
  output logic               sign,
  output logic               en,
  output logic [SCORE_W-1:0] best
);

  localparam int MS_W = (ALT_MS > 1) ? $clog2(ALT_MS) : 1;
  localparam logic [MS_W-1:0] MS_LAST = MS_W'(ALT_MS - 1);
  localparam logic [SCORE_W-1:0] MAX_S = SCORE_W'(MAX_SCORE);

  state_t             state;
  logic [SCORE_W-1:0] score;
  logic [SCORE_W-1:0] final_score;
  logic [MS_W-1:0]    ms_cnt;
  logic               start_q, pass_q, over_q;
  logic               start_rise, pass_rise, over_rise;
  logic               in_over, tick, swap;

  assign start_rise = game_start & ~start_q;
  assign pass_rise  = pass_pipe & ~pass_q;
  assign over_rise  = game_over & ~over_q;

  assign in_over = (state == OVER_SCORE) || (state == OVER_BEST);
  assign swap    = tick && (ms_cnt == MS_LAST);
  assign sign    = 1'b0;

  // A pass landing on the same edge as game over still counts toward best.
  assign final_score = pass_rise ? sat_inc(score, MAX_S) : score;

  ms_tick #(
    .CLK_FREQ(CLK_FREQ)
  ) u_ms_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (!in_over),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      score   <= '0;
      best    <= '0;
      ms_cnt  <= '0;
      start_q <= 1'b0;
      pass_q  <= 1'b0;
      over_q  <= 1'b0;
      data    <= '0;
      point   <= '0;
      en      <= 1'b0;
    end else begin
      start_q <= game_start;
      pass_q  <= pass_pipe;
      over_q  <= game_over;
      en      <= 1'b1;

      unique case (state)
        IDLE: begin
          if (start_rise) begin
            state <= PLAY;
            score <= '0;
          end
        end
        PLAY: begin
          if (start_rise) begin
            score <= '0;
          end else begin
            score <= final_score;
            if (over_rise) begin
              state <= OVER_SCORE;
              if (final_score > best) best <= final_score;
            end
          end
        end
        OVER_SCORE: begin
          if (start_rise) begin
            state <= PLAY;
            score <= '0;
          end else if (swap) begin
            state <= OVER_BEST;
          end
        end
        OVER_BEST: begin
          if (start_rise) begin
            state <= PLAY;
            score <= '0;
          end else if (swap) begin
            state <= OVER_SCORE;
          end
        end
        default: state <= IDLE;
      endcase

      // Both timers wrap together on a swap, so each OVER half starts from zero.
      if (!in_over) begin
        ms_cnt <= '0;
      end else if (tick) begin
        ms_cnt <= (ms_cnt == MS_LAST) ? '0 : ms_cnt + 1'b1;
      end

      if (state == IDLE || state == OVER_BEST) begin
        data  <= {6'b0, best};
        point <= POINT_BEST;
      end else begin
        data  <= {6'b0, score};
        point <= '0;
      end
    end
  end

endmodule

// File: tb/tb_score_tracker.sv
// Directed bench for score_tracker at 4 cycles/ms and a 3 ms alternation dwell.
module tb_score_tracker;

  logic        clk;
  logic        rst_n;
  logic        game_start;
  logic        pass_pipe;
  logic        game_over;
  logic [19:0] data;
  logic [5:0]  point;
  logic        sign;
  logic        en;
  logic [13:0] best;

  int n_tests = 0;
  int n_fail  = 0;

  score_tracker #(
    .CLK_FREQ (4000),
    .ALT_MS   (3),
    .MAX_SCORE(9999)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .game_start(game_start),
    .pass_pipe (pass_pipe),
    .game_over (game_over),
    .data      (data),
    .point     (point),
    .sign      (sign),
    .en        (en),
    .best      (best)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    game_start = 1'b1; @(negedge clk);
    game_start = 1'b0; @(negedge clk);
  endtask

  task automatic pulse_pass();
    pass_pipe = 1'b1; @(negedge clk);
    pass_pipe = 1'b0; @(negedge clk);
  endtask

  task automatic pulse_over();
    game_over = 1'b1; @(negedge clk);
    game_over = 1'b0; @(negedge clk);
  endtask

  initial begin
    game_start = 1'b0;
    pass_pipe  = 1'b0;
    game_over  = 1'b0;
    rst_n      = 1'b1;
    #2 rst_n   = 1'b0;
    @(negedge clk);
    chk("rst_data", data, 0);
    chk("rst_point", point, 0);
    chk("rst_en", en, 0);
    chk("rst_best", best, 0);
    rst_n = 1'b1;

    // Idle shows best with the decimal point.
    wait_n(5);
    chk("idle_data", data, 0);
    chk("idle_point", point, 1);
    chk("idle_en", en, 1);
    chk("idle_sign", sign, 0);

    // First game: 7 points, then alternation timing.
    pulse_start();
    chk("play_data0", data, 0);
    chk("play_point", point, 0);
    repeat (7) pulse_pass();
    chk("play_data7", data, 7);
    pulse_over();
    chk("over1_best", best, 7);
    chk("over1_data", data, 7);
    chk("over1_point", point, 0);
    wait_n(11);
    chk("alt1_pre_swap_point", point, 0);
    wait_n(1);
    chk("alt1_best_point", point, 1);
    chk("alt1_best_data", data, 7);
    wait_n(11);
    chk("alt1_pre_back_point", point, 1);
    wait_n(1);
    chk("alt1_back_point", point, 0);
    chk("alt1_back_data", data, 7);

    // Second game with a lower score keeps the best.
    pulse_start();
    repeat (3) pulse_pass();
    chk("g2_data", data, 3);
    pulse_over();
    chk("g2_best", best, 7);
    chk("g2_over_data", data, 3);
    wait_n(12);
    chk("g2_alt_data", data, 7);
    chk("g2_alt_point", point, 1);
    pulse_pass();
    pulse_over();
    chk("g2_ignored_best", best, 7);
    chk("g2_ignored_point", point, 1);
    wait_n(8);
    chk("g2_back_data", data, 3);
    chk("g2_back_point", point, 0);

    // Pass and over on the same edge: the point counts toward best.
    pulse_start();
    repeat (7) pulse_pass();
    pass_pipe = 1'b1;
    game_over = 1'b1;
    @(negedge clk);
    pass_pipe = 1'b0;
    game_over = 1'b0;
    @(negedge clk);
    chk("both_data", data, 8);
    chk("both_point", point, 0);
    chk("both_best", best, 8);
    wait_n(12);
    chk("both_alt_data", data, 8);
    chk("both_alt_point", point, 1);

    // A held pass level scores once.
    pulse_start();
    chk("g4_data0", data, 0);
    pass_pipe = 1'b1;
    wait_n(10);
    pass_pipe = 1'b0;
    wait_n(1);
    chk("held_pass", data, 1);

    // Start with over on the same edge: restart, best untouched.
    game_start = 1'b1;
    game_over  = 1'b1;
    @(negedge clk);
    game_start = 1'b0;
    game_over  = 1'b0;
    @(negedge clk);
    chk("start_over_data", data, 0);
    chk("start_over_point", point, 0);
    chk("start_over_best", best, 8);
    pulse_pass();
    chk("still_play", data, 1);

    // Saturation at MAX_SCORE.
    repeat (9997) pulse_pass();
    chk("sat_9998", data, 9998);
    repeat (3) pulse_pass();
    chk("sat_9999", data, 9999);
    pulse_over();
    chk("sat_best", best, 9999);
    wait_n(12);
    chk("sat_alt_point", point, 1);
    chk("sat_alt_data", data, 9999);

    // Asynchronous reset in the middle of OVER_BEST.
    wait_n(3);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_data", data, 0);
    chk("arst_point", point, 0);
    chk("arst_en", en, 0);
    chk("arst_best", best, 0);
    chk("arst_sign", sign, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_n(2);
    chk("post_rst_en", en, 1);
    chk("post_rst_point", point, 1);
    chk("post_rst_data", data, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/score_tracker.md
# score_tracker

Game-score bookkeeping stage that sits directly upstream of the six-digit seven-segment driver. It counts pipes passed during play, keeps the session best score, and presents a binary value plus decimal-point/sign/enable controls on the driver's `data`/`point`/`sign`/`en` inputs. After game over it alternates the display between the final score and the best score at a fixed period.

## Interface
Parameters:
- `CLK_FREQ`, default 50_000_000. System clock frequency in Hz.
- `ALT_MS`, default 1000. Dwell time in ms for each half of the score/best alternation.
- `MAX_SCORE`, default 9999. Saturation value, sized to the four digits the driver scans.

Ports:
- `clk`, input, 1. System clock.
- `rst_n`, input, 1. Reset: asynchronous, active-low.
- `game_start`, input, 1. Level from game logic; its rising edge starts or restarts a game.
- `pass_pipe`, input, 1. Level from game logic; each rising edge scores one point.
- `game_over`, input, 1. Level from game logic; its rising edge ends the game.
- `data`, output, 20. Binary value to display. Upper 6 bits are always 0.
- `point`, output, 6. Decimal-point mask. `6'b000001` while best is shown, else 0.
- `sign`, output, 1. Always 0.
- `en`, output, 1. Display enable.
- `best`, output, 14. Current best score, for other consumers.

## Operation
- All three control inputs share the `clk` domain. Each is edge-detected against its own previous-cycle register. Only rising edges act.
- State machine `IDLE`, `PLAY`, `OVER_SCORE`, `OVER_BEST`:
  - **IDLE:** `data` = `best`, `point` = 1. A start edge → `PLAY` with `score` cleared to 0.
  - **PLAY:** `data` = `score`, `point` = 0.
    - A pass edge sets `score` = min(`score`+1, `MAX_SCORE`).
    - A start edge clears `score` and stays in `PLAY`.
    - An over edge → `OVER_SCORE`, and sets `best` = max(`best`, final score).
  - **OVER_SCORE:** `data` = `score`, `point` = 0. After `ALT_MS` → `OVER_BEST`.
  - **OVER_BEST:** `data` = `best`, `point` = 1. After `ALT_MS` → `OVER_SCORE`.
  - In either OVER state, a start edge → `PLAY` and clears `score`.
  - Pass and over edges outside `PLAY` are ignored.
- Simultaneous events in `PLAY`:
  - Pass and over together: the point counts. The best comparison uses the incremented score.
  - Start together with over or pass: start wins. `score` becomes 0, state stays `PLAY`, and `best` is unchanged.
- Alternation timer:
  - A 1 ms tick prescaler counts `CLK_FREQ/1000` cycles.
  - A ms counter runs 0..`ALT_MS`-1.
  - Both clear on entry to `OVER_SCORE` and on every OVER-state change. Both are held at 0 outside the OVER states.
- Width rules:
  - `score` and `best` are 14 bits.
  - Compare and saturate are unsigned.
  - `data` = {6'b0, selected 14-bit value}.
- `best` persists across games and is cleared only by reset.

## Timing
- Reset values:
  - state `IDLE`, `score` = 0, `best` = 0.
  - `data` = 0, `point` = 0, `sign` = 0, `en` = 0.
  - All edge-detect registers and timers 0.
- `en` goes to 1 on the first clock after reset release and stays 1.
- Latency:
  - An input first sampled high at edge k (low at k-1) updates state/`score`/`best` at edge k.
  - Registered `data`/`point` reflect the change at edge k+1.
- Alternation: the first swap from `OVER_SCORE` occurs exactly `ALT_MS`×`CLK_FREQ`/1000 cycles after entry, then every period thereafter.
- Asserting `rst_n` mid-game returns to the reset values asynchronously. `best` is lost.

## Structure
- Package `score_pkg`:
  - state enum.
  - `SCORE_W` = 14.
  - `POINT_BEST` = 6'b000001.
- Sub-module `ms_tick`: parameter `CLK_FREQ`; inputs `clk`, `rst_n`, `clr`; output `tick`, a 1-cycle pulse each ms.
- The FSM, counters and output register live in `score_tracker`.

## Test plan
The bench uses `CLK_FREQ` = 4000 (4 cycles/ms) and `ALT_MS` = 3.

1. Reset, then idle 5 cycles → `data` = 0, `point` = 1, `en` = 1, `sign` = 0.
2. Start, then 7 pass pulses, then over → `data` = 7 during play; `best` = 7. After 12 cycles, `data` = 7 with `point` = 1. After 12 more, `point` = 0.
3. Second game with 3 passes, then over → `best` stays 7. Alternation shows 3 then 7.
4. Force `score` to 9998, then send 3 passes → `data` saturates at 9999.
5. Pass and over asserted on the same cycle at `score` = 7 with `best` = 7 → `best` = 8, state `OVER_SCORE`.
6. Hold `pass_pipe` high for 10 cycles → exactly +1. Assert reset mid-`OVER_BEST` → all outputs at reset values, `best` = 0.
